// File: rtl/conv_interleaver_pkg.sv
// conv_interleaver_pkg: shared symbol width, DVB constants and per-branch delay helper
package conv_interleaver_pkg;

    localparam int SYM_W = 8;
    localparam int DVB_I = 12;
    localparam int DVB_M = 17;

    // Branch j holds j*M entries when interleaving, (I-1-j)*M when deinterleaving
    function automatic int branch_delay(int j, int i, int m, int mode);
        return (mode != 0) ? (i - 1 - j) * m : j * m;
    endfunction

    // Storage summed over all branches, identical for both modes
    function automatic int total_storage(int i, int m);
        return m * i * (i - 1) / 2;
    endfunction

endpackage

// File: rtl/conv_interleaver_if.sv
// conv_interleaver_if: symbol stream (valid, data, sync) between FEC stages
interface conv_interleaver_if #(
    parameter int W = 8
);

    logic         valid;
    logic [W-1:0] data;
    logic         sync;

    modport master (output valid, output data, output sync);
    modport slave  (input  valid, input  data, input  sync);

endinterface

// File: rtl/conv_interleaver_delay_line.sv
// enabled_delay_line: DEPTH-entry symbol delay that advances only when enabled
module enabled_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused;
            assign unused = ^{clk, reset, en};
            assign q      = d;
        end else begin : g_line
            localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
            logic [W-1:0]  mem [DEPTH];
            logic [PW-1:0] ptr;
            assign q = mem[ptr];
            // Circular buffer: the slot at ptr is the oldest entry; replace it with d and move on
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ptr <= '0;
                    for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
                end else if (en) begin
                    mem[ptr] <= d;
                    ptr      <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/conv_interleaver.sv
// conv_interleaver: generic Forney convolutional interleaver / deinterleaver with sync-aligned commutator
module conv_interleaver
    import conv_interleaver_pkg::*;
#(
    parameter int W            = SYM_W,
    parameter int I            = DVB_I,
    parameter int M            = DVB_M,
    parameter int DEINTERLEAVE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_interleaver_if.slave      up,
    conv_interleaver_if.master     dn,
    output logic                   sync_err
);

    localparam int BW = $clog2(I);

    generate
        if (I < 2)  begin : g_bad_i $error("conv_interleaver needs at least two branches"); end
        if (M < 1)  begin : g_bad_m $error("conv_interleaver needs a unit delay of at least one"); end
    endgenerate

    logic [BW-1:0] br;
    logic [BW-1:0] sel;
    logic [W-1:0]  q [I];
    logic [W-1:0]  y;

    // A sync symbol is always forced onto branch 0, whatever the commutator says
    assign sel = up.sync ? '0 : br;
    assign y   = q[sel];

    generate
        for (genvar j = 0; j < I; j++) begin : g_branch
            enabled_delay_line #(
                .W     (W),
                .DEPTH (branch_delay(j, I, M, DEINTERLEAVE))
            ) u_line (
                .clk   (clk),
                .reset (reset),
                .en    (up.valid && sel == BW'(j)),
                .d     (up.data),
                .q     (q[j])
            );
        end
    endgenerate

    // Commutator: step one branch per accepted symbol; a sync realigns so the next symbol uses branch 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) br <= '0;
        else if (up.valid) br <= up.sync ? BW'(1) : ((br == BW'(I - 1)) ? '0 : br + 1'b1);
    end

    // Output registers: data and sync hold through idle cycles, valid and sync_err follow each cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dn.valid <= 1'b0;
            dn.data  <= '0;
            dn.sync  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            dn.valid <= up.valid;
            sync_err <= up.valid && up.sync && br != '0;
            if (up.valid) begin
                dn.data <= y;
                dn.sync <= up.sync;
            end
        end
    end

endmodule

// File: tb/tb_conv_interleaver.sv
// tb_conv_interleaver: randomized checks of interleaver, deinterleaver loopback and DVB framing
module tb_conv_interleaver;

    localparam int SI = 3;
    localparam int SM = 2;
    localparam int BI = 12;
    localparam int BM = 17;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ea, eb, ec, ed;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    conv_interleaver_if #(.W(8)) ia ();
    conv_interleaver_if #(.W(8)) oa ();
    conv_interleaver_if #(.W(8)) ob ();
    conv_interleaver_if #(.W(8)) ic ();
    conv_interleaver_if #(.W(8)) oc ();
    conv_interleaver_if #(.W(8)) od ();

    conv_interleaver #(.W(8), .I(SI), .M(SM), .DEINTERLEAVE(0)) dut_a (.clk(clk), .reset(reset), .up(ia), .dn(oa), .sync_err(ea));
    conv_interleaver #(.W(8), .I(SI), .M(SM), .DEINTERLEAVE(1)) dut_b (.clk(clk), .reset(reset), .up(oa), .dn(ob), .sync_err(eb));
    conv_interleaver #(.W(8), .I(BI), .M(BM), .DEINTERLEAVE(0)) dut_c (.clk(clk), .reset(reset), .up(ic), .dn(oc), .sync_err(ec));
    conv_interleaver #(.W(8), .I(BI), .M(BM), .DEINTERLEAVE(1)) dut_d (.clk(clk), .reset(reset), .up(oc), .dn(od), .sync_err(ed));

    // Reference model for the small interleaver: one FIFO per branch preloaded with zeros
    logic [7:0] qm [SI][$];
    int br_m;

    task automatic model_reset();
        for (int j = 0; j < SI; j++) begin
            qm[j].delete();
            repeat (j * SM) qm[j].push_back(8'h00);
        end
        br_m = 0;
    endtask

    task automatic model_step(input logic s, input logic [7:0] d, output logic [7:0] e, output logic err);
        int b;
        b = s ? 0 : br_m;
        err = s && (br_m != 0);
        br_m = s ? 1 : (br_m + 1) % SI;
        if (qm[b].size() == 0) e = d;
        else begin
            e = qm[b].pop_front();
            qm[b].push_back(d);
        end
    endtask

    task automatic step_a(input logic v, input logic s, input logic [7:0] d);
        ia.valid = v;
        ia.sync  = s;
        ia.data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_c(input logic v, input logic s, input logic [7:0] d);
        ic.valid = v;
        ic.sync  = s;
        ic.data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ia.valid = 1'b0; ia.sync = 1'b0; ia.data = 8'h00;
        ic.valid = 1'b0; ic.sync = 1'b0; ic.data = 8'h00;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        ia.valid = 1'b0; ia.sync = 1'b0; ia.data = 8'h00;
        ic.valid = 1'b0; ic.sync = 1'b0; ic.data = 8'h00;
        reset = 1'b0;
        #12;
        total++;
        if ({oa.valid, oa.sync, ea, oa.data} !== 11'd0) begin
            bad++;
            $display("FAIL reset_a got=%h want=0", {oa.valid, oa.sync, ea, oa.data});
        end
        total++;
        if ({ob.valid, oc.valid, od.valid, eb, ec, ed, ob.data, oc.data, od.data} !== 30'd0) begin
            bad++;
            $display("FAIL reset_bcd got=%h want=0", {ob.valid, oc.valid, od.valid, eb, ec, ed, ob.data, oc.data, od.data});
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        logic [7:0] tbl [15] = '{8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h07, 8'h02,
                                 8'h00, 8'h0A, 8'h05, 8'h00, 8'h0D, 8'h08, 8'h03};
        logic [7:0] e;
        logic err;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            model_step(n == 0, 8'(n + 1), e, err);
            step_a(1'b1, n == 0, 8'(n + 1));
            total++;
            if ({oa.valid, oa.sync, ea, oa.data} !== {1'b1, n == 0, err, e}) begin
                bad++;
                $display("FAIL stream n=%0d got v%b s%b e%b %h want v1 s%b e%b %h", n, oa.valid, oa.sync, ea, oa.data, n == 0, err, e);
            end
            if (n < 15) begin
                total++;
                if (oa.data !== tbl[n]) begin
                    bad++;
                    $display("FAIL stream_table n=%0d got=%h want=%h", n, oa.data, tbl[n]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        logic [7:0] e;
        logic [7:0] last;
        logic err;
        int k;
        do_reset();
        k = 0;
        last = 8'h00;
        for (int n = 0; n < 60; n++) begin
            if (n % 2 == 0) begin
                model_step(k == 0, 8'(k + 1), e, err);
                step_a(1'b1, k == 0, 8'(k + 1));
                k++;
                last = e;
                total++;
                if ({oa.valid, oa.data} !== {1'b1, e}) begin
                    bad++;
                    $display("FAIL gaps_valid n=%0d got v%b %h want v1 %h", n, oa.valid, oa.data, e);
                end
            end else begin
                step_a(1'b0, 1'b0, 8'($urandom));
                total++;
                if ({oa.valid, ea, oa.data} !== {1'b0, 1'b0, last}) begin
                    bad++;
                    $display("FAIL gaps_idle n=%0d got v%b e%b %h want v0 e0 %h", n, oa.valid, ea, oa.data, last);
                end
            end
        end
    endtask

    task automatic test_sync_misalign();
        logic [7:0] e;
        logic [7:0] d;
        logic err;
        logic s;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            s = (n == 0) || (n == 1) || (n > 2 && $urandom_range(0, 4) == 0);
            model_step(s, d, e, err);
            step_a(1'b1, s, d);
            if (n == 1) begin
                total++;
                if ({ea, oa.sync, oa.data} !== {1'b1, 1'b1, d}) begin
                    bad++;
                    $display("FAIL misalign_hit got e%b s%b %h want e1 s1 %h", ea, oa.sync, oa.data, d);
                end
            end
            total++;
            if ({oa.valid, oa.sync, ea, oa.data} !== {1'b1, s, err, e}) begin
                bad++;
                $display("FAIL misalign n=%0d got v%b s%b e%b %h want v1 s%b e%b %h", n, oa.valid, oa.sync, ea, oa.data, s, err, e);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] e;
        logic [7:0] d;
        logic err;
        do_reset();
        for (int n = 0; n < 10; n++) step_a(1'b1, n == 0, 8'($urandom_range(1, 255)));
        ia.valid = 1'b1;
        ia.data  = 8'h5A;
        #3;
        reset = 1'b0;
        #1;
        total++;
        if ({oa.valid, oa.sync, ea, oa.data} !== 11'd0) begin
            bad++;
            $display("FAIL midreset_async got=%h want=0", {oa.valid, oa.sync, ea, oa.data});
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom_range(1, 255));
            model_step(1'b0, d, e, err);
            step_a(1'b1, 1'b0, d);
            total++;
            if ({oa.valid, ea, oa.data} !== {1'b1, err, e}) begin
                bad++;
                $display("FAIL midreset n=%0d got v%b e%b %h want v1 e%b %h", n, oa.valid, ea, oa.data, err, e);
            end
        end
    endtask

    task automatic test_loopback_small();
        logic [7:0] xs [$];
        logic [7:0] got [$];
        logic [7:0] d;
        do_reset();
        for (int n = 0; n < 202; n++) begin
            d = 8'($urandom);
            if (n < 200) xs.push_back(d);
            step_a(n < 200, n < 200 && n % 3 == 0, d);
            if (ob.valid) got.push_back(ob.data);
            total++;
            if ({ea, eb} !== 2'b00) begin
                bad++;
                $display("FAIL loop_small_err n=%0d got %b%b want 00", n, ea, eb);
            end
        end
        total++;
        if (got.size() !== 200) begin
            bad++;
            $display("FAIL loop_small_count got=%0d want=200", got.size());
        end
        for (int k = SI * SM * (SI - 1); k < got.size() && k < 200; k++) begin
            total++;
            if (got[k] !== xs[k - SI * SM * (SI - 1)]) begin
                bad++;
                $display("FAIL loop_small k=%0d got=%h want=%h", k, got[k], xs[k - SI * SM * (SI - 1)]);
            end
        end
    endtask

    task automatic test_dvb_loopback();
        localparam int N = 2600;
        localparam int DLY = BM * BI * (BI - 1);
        logic [7:0] xs [$];
        logic [7:0] got [$];
        logic [7:0] d;
        logic [7:0] e;
        logic s;
        int j;
        do_reset();
        for (int n = 0; n < N + 2; n++) begin
            s = (n < N) && (n % 204 == 0);
            d = s ? (((n / 204) % 8 == 0) ? 8'hB8 : 8'h47) : 8'($urandom);
            if (n < N) xs.push_back(d);
            step_c(n < N, s, d);
            if (od.valid) got.push_back(od.data);
            total++;
            if ({ec, ed} !== 2'b00) begin
                bad++;
                $display("FAIL dvb_err n=%0d got %b%b want 00", n, ec, ed);
            end
            if (n < N) begin
                j = n % BI;
                e = (n >= j * BM * BI) ? xs[n - j * BM * BI] : 8'h00;
                total++;
                if ({oc.valid, oc.sync, oc.data} !== {1'b1, s, e}) begin
                    bad++;
                    $display("FAIL dvb_int n=%0d got v%b s%b %h want v1 s%b %h", n, oc.valid, oc.sync, oc.data, s, e);
                end
            end
        end
        total++;
        if (got.size() !== N) begin
            bad++;
            $display("FAIL dvb_count got=%0d want=%0d", got.size(), N);
        end
        for (int k = DLY; k < got.size() && k < N; k++) begin
            total++;
            if (got[k] !== xs[k - DLY]) begin
                bad++;
                $display("FAIL dvb_loop k=%0d got=%h want=%h", k, got[k], xs[k - DLY]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_sync_misalign();
        test_reset_midstream();
        test_loopback_small();
        test_dvb_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
